gate_truth_table_observer: RTL



---
 rtl/gate_truth_table_observer.sv | 132 +++++++++++++
 1 files changed

// File: rtl/gate_truth_table_observer.sv
// gate_truth_table_observer
//   Observes (a, b, y) samples from a two-input gate under test. It builds the
//   four-row truth table and confirms each row after REPEATS agreeing
//   observations. A contradictory observation flags a conflict. Once all rows
//   are confirmed, the gate is classified as AND/NAND/OR/NOR/XOR/XNOR/other.
//
// Ports
//   clk, rst_n        clock, async active-low reset
//   clear             synchronous restart (wins over in_valid)
//   in_valid/in_ready sample handshake; in_ready=1 only while collecting
//   in_a, in_b, in_y  gate inputs and observed gate output
//   truth_table[3:0]  bit {a,b} holds observed y for that row
//                     (`table` is a reserved word, hence the longer name)
//   seen[3:0]         bit {a,b} set once that row is confirmed
//   done              all rows confirmed without conflict
//   conflict          a sample disagreed with the recorded row value
//   gate_code[2:0]    0 AND,1 NAND,2 OR,3 NOR,4 XOR,5 XNOR,6 other
//   gate_known        gate_code names one of the six standard gates
module gate_truth_table_observer #(
   parameter int REPEATS = 2
) (
   input  logic       clk,
   input  logic       rst_n,
   input  logic       clear,
   input  logic       in_valid,
   output logic       in_ready,
   input  logic       in_a,
   input  logic       in_b,
   input  logic       in_y,
   output logic [3:0] truth_table,
   output logic [3:0] seen,
   output logic       done,
   output logic       conflict,
   output logic [2:0] gate_code,
   output logic       gate_known
);

   localparam logic [3:0] REP = 4'(REPEATS);

   typedef enum logic [1:0] {
      COLLECT = 2'd0,
      DONE    = 2'd1,
      ERROR   = 2'd2
   } state_t;

   state_t          state_q, state_d;
   logic [3:0]      table_q, table_d;
   logic [3:0][3:0] cnt_q, cnt_d;
   logic [3:0]      seen_q, seen_d;
   logic [2:0]      gate_code_q, gate_code_d;
   logic            gate_known_q, gate_known_d;

   logic       accept;
   logic [1:0] idx;

   assign idx    = {in_a, in_b};
   assign accept = in_valid && (state_q == COLLECT) && !clear;

   always_comb begin
      state_d      = state_q;
      table_d      = table_q;
      cnt_d        = cnt_q;
      gate_code_d  = gate_code_q;
      gate_known_d = gate_known_q;

      if (clear) begin
         state_d      = COLLECT;
         table_d      = '0;
         cnt_d        = '0;
         gate_code_d  = '0;
         gate_known_d = 1'b0;
      end else if (accept) begin
         if (cnt_q[idx] == 4'd0) begin
            table_d[idx] = in_y;
            cnt_d[idx]   = 4'd1;
         end else if (in_y == table_q[idx]) begin
            if (cnt_q[idx] < REP) cnt_d[idx] = cnt_q[idx] + 4'd1;
         end else begin
            // Conflicting sample is dropped; table/cnt keep the evidence.
            state_d = ERROR;
         end
      end

      for (int i = 0; i < 4; i++) seen_d[i] = (cnt_d[i] >= REP);

      // Classify from the table as it will be once this sample lands, so the
      // code is registered on the same edge that enters DONE.
      if (accept && state_d == COLLECT && (&seen_d)) begin
         state_d      = DONE;
         gate_known_d = 1'b1;
         unique case (table_d)
            4'b1000: gate_code_d = 3'd0;
            4'b0111: gate_code_d = 3'd1;
            4'b1110: gate_code_d = 3'd2;
            4'b0001: gate_code_d = 3'd3;
            4'b0110: gate_code_d = 3'd4;
            4'b1001: gate_code_d = 3'd5;
            default: begin
               gate_code_d  = 3'd6;
               gate_known_d = 1'b0;
            end
         endcase
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q      <= COLLECT;
         table_q      <= '0;
         cnt_q        <= '0;
         seen_q       <= '0;
         gate_code_q  <= '0;
         gate_known_q <= 1'b0;
      end else begin
         state_q      <= state_d;
         table_q      <= table_d;
         cnt_q        <= cnt_d;
         seen_q       <= seen_d;
         gate_code_q  <= gate_code_d;
         gate_known_q <= gate_known_d;
      end
   end

   assign in_ready    = (state_q == COLLECT);
   assign done        = (state_q == DONE);
   assign conflict    = (state_q == ERROR);
   assign truth_table = table_q;
   assign seen        = seen_q;
   assign gate_code   = gate_code_q;
   assign gate_known  = gate_known_q;

endmodule
